// File: rtl/elevator_scan_controller_if.sv
// Request bus between the floor-button logic and the elevator controller.
//
// Signals:
//   req_valid  - one-cycle request strobe
//   req_floor  - requested floor index, valid with req_valid
//
// Modports:
//   master - the button/request logic that drives requests
//   slave  - the controller that captures them
interface elevator_scan_controller_if #(
    parameter int FLOOR_W = 3
);
    logic               req_valid;
    logic [FLOOR_W-1:0] req_floor;

    modport master (output req_valid, output req_floor);
    modport slave  (input  req_valid, input  req_floor);
endinterface

// File: rtl/elevator_scan_controller.sv
// SCAN-policy elevator controller. It owns the pending-request bitmap, the
// current-floor register and the travel/door timer. The car keeps its
// direction while requests remain ahead of it, and reverses only when none
// are left in that direction.
//
// Ports:
//   clock         - single clock, rising edge
//   reset         - synchronous, active-high
//   iniciar       - leaves OFF and starts the controller
//   reqBus        - request bus (req_valid strobe, req_floor index)
//   current_floor - car position
//   pending       - outstanding request bitmap
//   moving_up     - car is travelling up
//   moving_down   - car is travelling down
//   door_open     - door is open
//   served        - one-cycle pulse on the first door cycle at a floor
//   served_floor  - floor being served, valid with served (else 0)
//   db_state      - state code for debug
module elevator_scan_controller #(
    parameter int N_FLOORS      = 8,
    parameter int FLOOR_W       = 3,
    parameter int TRAVEL_CYCLES = 100,
    parameter int DOOR_CYCLES   = 200,
    parameter int TIMER_W       = 16
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        iniciar,
    elevator_scan_controller_if.slave   reqBus,
    output logic [FLOOR_W-1:0]          current_floor,
    output logic [N_FLOORS-1:0]         pending,
    output logic                        moving_up,
    output logic                        moving_down,
    output logic                        door_open,
    output logic                        served,
    output logic [FLOOR_W-1:0]          served_floor,
    output logic [2:0]                  db_state
);

    typedef enum logic [2:0] {
        OFF    = 3'd0,
        INIT   = 3'd1,
        IDLE   = 3'd2,
        DECIDE = 3'd3,
        MOVE   = 3'd4,
        STEP   = 3'd5,
        DOOR   = 3'd6
    } stateT;

    localparam logic [TIMER_W-1:0] TRAVEL_LAST = TIMER_W'(TRAVEL_CYCLES - 1);
    localparam logic [TIMER_W-1:0] DOOR_LAST   = TIMER_W'(DOOR_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMER_ONE   = TIMER_W'(1);
    localparam logic [FLOOR_W-1:0] FLOOR_ONE   = FLOOR_W'(1);

    stateT                state;
    stateT                stateNext;
    logic                 dir;
    logic                 dirNext;
    logic [FLOOR_W-1:0]   floorReg;
    logic [FLOOR_W-1:0]   floorNext;
    logic [N_FLOORS-1:0]  pendingReg;
    logic [N_FLOORS-1:0]  pendingNext;
    logic [TIMER_W-1:0]   timer;
    logic [TIMER_W-1:0]   timerNext;

    logic [N_FLOORS-1:0]  hereMask;
    logic [N_FLOORS-1:0]  aboveMask;
    logic [N_FLOORS-1:0]  belowMask;
    logic [N_FLOORS-1:0]  reqMask;
    logic                 captureEnable;

    // Floor masks relative to the car, plus a one-hot of the requested floor.
    // Building them with loops keeps every index in range: a request at or
    // beyond N_FLOORS produces an empty reqMask and is therefore dropped.
    always_comb begin
        hereMask  = '0;
        aboveMask = '0;
        belowMask = '0;
        reqMask   = '0;
        for (int i = 0; i < N_FLOORS; i++) begin
            if (int'(floorReg) == i) hereMask[i] = 1'b1;
            if (i > int'(floorReg))  aboveMask[i] = 1'b1;
            if (i < int'(floorReg))  belowMask[i] = 1'b1;
            if (int'(reqBus.req_floor) == i) reqMask[i] = 1'b1;
        end
    end

    // Requests are accepted while the car is active. During DOOR the current
    // floor is already being served, so a repeat of it is not re-queued.
    always_comb begin
        captureEnable = 1'b0;
        if (reqBus.req_valid) begin
            case (state)
                IDLE, DECIDE, MOVE, STEP: captureEnable = 1'b1;
                DOOR:    captureEnable = ~|(reqMask & hereMask);
                default: captureEnable = 1'b0;
            endcase
        end
    end

    // Next-state logic. The timer rests at zero outside MOVE and DOOR, so it
    // is already cleared on entry to either of them. In DECIDE the clear of
    // the served bit is applied after any capture, so clear wins.
    always_comb begin
        stateNext   = state;
        dirNext     = dir;
        floorNext   = floorReg;
        pendingNext = pendingReg;
        timerNext   = '0;
        if (captureEnable) pendingNext = pendingReg | reqMask;
        case (state)
            OFF: begin
                if (iniciar) stateNext = INIT;
            end
            INIT: begin
                pendingNext = '0;
                floorNext   = '0;
                dirNext     = 1'b1;
                stateNext   = IDLE;
            end
            IDLE: begin
                if (|pendingReg) stateNext = DECIDE;
            end
            DECIDE: begin
                if (|(pendingReg & hereMask)) begin
                    pendingNext = pendingNext & ~hereMask;
                    stateNext   = DOOR;
                end else if (dir && |(pendingReg & aboveMask)) begin
                    stateNext = MOVE;
                end else if (|(pendingReg & belowMask)) begin
                    dirNext   = 1'b0;
                    stateNext = MOVE;
                end else if (|(pendingReg & aboveMask)) begin
                    dirNext   = 1'b1;
                    stateNext = MOVE;
                end else begin
                    stateNext = IDLE;
                end
            end
            MOVE: begin
                if (timer == TRAVEL_LAST) stateNext = STEP;
                else                      timerNext = timer + TIMER_ONE;
            end
            STEP: begin
                floorNext = dir ? (floorReg + FLOOR_ONE) : (floorReg - FLOOR_ONE);
                stateNext = DECIDE;
            end
            DOOR: begin
                if (timer == DOOR_LAST) stateNext = DECIDE;
                else                    timerNext = timer + TIMER_ONE;
            end
            default: begin
                stateNext = OFF;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= OFF;
            dir        <= 1'b1;
            floorReg   <= '0;
            pendingReg <= '0;
            timer      <= '0;
        end else begin
            state      <= stateNext;
            dir        <= dirNext;
            floorReg   <= floorNext;
            pendingReg <= pendingNext;
            timer      <= timerNext;
        end
    end

    // Outputs are registers or a decode of registered state only. The timer
    // is zero only in the first DOOR cycle, which marks the served pulse.
    assign current_floor = floorReg;
    assign pending       = pendingReg;
    assign moving_up     = (state == MOVE) &&  dir;
    assign moving_down   = (state == MOVE) && !dir;
    assign door_open     = (state == DOOR);
    assign served        = (state == DOOR) && (timer == '0);
    assign served_floor  = served ? floorReg : '0;
    assign db_state      = state;

endmodule

// File: tb/tb_elevator_scan_controller.sv
// Self-checking bench for elevator_scan_controller. A reference model tracks
// the car as an activity plus a countdown of remaining cycles and checks
// every output after every clock edge; a vector table and hand-written
// sequences add fixed expectations for reset, latency, SCAN order and
// ignored-request corner cases, followed by randomized traffic.
module tb_elevator_scan_controller;

    localparam int NF     = 8;
    localparam int FW     = 4;
    localparam int TRAVEL = 4;
    localparam int DOORC  = 6;

    localparam int S_OFF = 0, S_INIT = 1, S_IDLE = 2, S_DECIDE = 3;
    localparam int S_MOVE = 4, S_STEP = 5, S_DOOR = 6;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          iniciar = 1'b0;
    logic [FW-1:0] current_floor;
    logic [FW-1:0] served_floor;
    logic [NF-1:0] pending;
    logic          moving_up, moving_down, door_open, served;
    logic [2:0]    db_state;

    elevator_scan_controller_if #(.FLOOR_W(FW)) reqBus();

    elevator_scan_controller #(
        .N_FLOORS(NF), .FLOOR_W(FW), .TRAVEL_CYCLES(TRAVEL),
        .DOOR_CYCLES(DOORC), .TIMER_W(16)
    ) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .reqBus(reqBus),
        .current_floor(current_floor), .pending(pending),
        .moving_up(moving_up), .moving_down(moving_down),
        .door_open(door_open), .served(served),
        .served_floor(served_floor), .db_state(db_state)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: activity, floor, request set, direction, cycles left.
    int        mAct   = S_OFF;
    int        mFloor = 0;
    bit [NF-1:0] mPend = '0;
    bit        mDir   = 1'b1;
    int        mLeft  = 0;

    typedef struct {
        bit r; bit ini; bit v; int f;
        int expPend; int expFloor; int expState; int expServed;
    } vecT;

    task automatic check(string name, int actual, int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Advance the model by one clock using the inputs seen at that edge.
    task automatic modelStep(bit r, bit ini, bit v, int f);
        bit [NF-1:0] np;
        bit ahead, behind;
        if (r) begin
            mAct = S_OFF; mFloor = 0; mPend = '0; mDir = 1'b1; mLeft = 0;
            return;
        end
        np = mPend;
        if (v && f < NF) begin
            if (mAct == S_IDLE || mAct == S_DECIDE || mAct == S_MOVE || mAct == S_STEP)
                np[f] = 1'b1;
            else if (mAct == S_DOOR && f != mFloor)
                np[f] = 1'b1;
        end
        ahead = 0; behind = 0;
        for (int i = 0; i < NF; i++) begin
            if (mPend[i] && i > mFloor) ahead = 1;
            if (mPend[i] && i < mFloor) behind = 1;
        end
        case (mAct)
            S_OFF:  if (ini) mAct = S_INIT;
            S_INIT: begin np = '0; mFloor = 0; mDir = 1'b1; mAct = S_IDLE; end
            S_IDLE: if (mPend != 0) mAct = S_DECIDE;
            S_DECIDE: begin
                if (mPend[mFloor]) begin
                    np[mFloor] = 1'b0; mAct = S_DOOR; mLeft = DOORC;
                end else if (mDir && ahead) begin
                    mAct = S_MOVE; mLeft = TRAVEL;
                end else if (behind) begin
                    mDir = 1'b0; mAct = S_MOVE; mLeft = TRAVEL;
                end else if (ahead) begin
                    mDir = 1'b1; mAct = S_MOVE; mLeft = TRAVEL;
                end else begin
                    mAct = S_IDLE;
                end
            end
            S_MOVE: begin mLeft--; if (mLeft == 0) mAct = S_STEP; end
            S_STEP: begin mFloor = mDir ? mFloor + 1 : mFloor - 1; mAct = S_DECIDE; end
            S_DOOR: begin mLeft--; if (mLeft == 0) mAct = S_DECIDE; end
            default: mAct = S_OFF;
        endcase
        mPend = np;
    endtask

    task automatic checkOutput();
        bit expServed;
        expServed = (mAct == S_DOOR) && (mLeft == DOORC);
        check("db_state", int'(db_state), mAct);
        check("current_floor", int'(current_floor), mFloor);
        check("pending", int'(pending), int'(mPend));
        check("moving_up", int'(moving_up), int'(mAct == S_MOVE && mDir));
        check("moving_down", int'(moving_down), int'(mAct == S_MOVE && !mDir));
        check("door_open", int'(door_open), int'(mAct == S_DOOR));
        check("served", int'(served), int'(expServed));
        check("served_floor", int'(served_floor), expServed ? mFloor : 0);
    endtask

    task automatic applyStimulus(bit r, bit ini, bit v, int f);
        reset = r;
        iniciar = ini;
        reqBus.req_valid = v;
        reqBus.req_floor = FW'(f);
        @(posedge clock);
        modelStep(r, ini, v, f);
        #1;
        checkOutput();
    endtask

    task automatic startup();
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0);
        check("startup_idle", int'(db_state), S_IDLE);
    endtask

    // Run until a door cycle has been seen and the car is back in IDLE.
    task automatic waitDoorThenIdle(string name, int budget);
        bit seenDoor = 0;
        bit ok = 0;
        for (int n = 0; n < budget && !ok; n++) begin
            applyStimulus(0, 0, 0, 0);
            if (door_open) seenDoor = 1;
            if (seenDoor && db_state == 3'(S_IDLE)) ok = 1;
        end
        check(name, int'(ok), 1);
    endtask

    vecT vecs[16];

    initial begin
        int servedAt, servedFl, upCnt, doorCnt, servedCnt;
        bit found, hit, downEarly, upLate, seen6;
        int order[$];

        reqBus.req_valid = 1'b0;
        reqBus.req_floor = '0;

        // Reset, power-up, ignored requests and a local serve, edge by edge.
        vecs[0]  = '{1, 0, 0, 0, 0, 0, S_OFF,    0};
        vecs[1]  = '{0, 0, 1, 3, 0, 0, S_OFF,    0};
        vecs[2]  = '{0, 1, 0, 0, 0, 0, S_INIT,   0};
        vecs[3]  = '{0, 0, 1, 5, 0, 0, S_IDLE,   0};
        vecs[4]  = '{0, 0, 1, 9, 0, 0, S_IDLE,   0};
        vecs[5]  = '{0, 0, 0, 0, 0, 0, S_IDLE,   0};
        vecs[6]  = '{0, 0, 1, 0, 1, 0, S_IDLE,   0};
        vecs[7]  = '{0, 0, 0, 0, 1, 0, S_DECIDE, 0};
        vecs[8]  = '{0, 0, 0, 0, 0, 0, S_DOOR,   1};
        vecs[9]  = '{0, 0, 1, 0, 0, 0, S_DOOR,   0};
        vecs[10] = '{0, 0, 1, 2, 4, 0, S_DOOR,   0};
        vecs[11] = '{0, 0, 0, 0, 4, 0, S_DOOR,   0};
        vecs[12] = '{0, 0, 0, 0, 4, 0, S_DOOR,   0};
        vecs[13] = '{0, 0, 0, 0, 4, 0, S_DOOR,   0};
        vecs[14] = '{0, 0, 0, 0, 4, 0, S_DECIDE, 0};
        vecs[15] = '{0, 0, 0, 0, 4, 0, S_MOVE,   0};

        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].r, vecs[i].ini, vecs[i].v, vecs[i].f);
            check($sformatf("vec%0d_pending", i), int'(pending), vecs[i].expPend);
            check($sformatf("vec%0d_floor", i), int'(current_floor), vecs[i].expFloor);
            check($sformatf("vec%0d_state", i), int'(db_state), vecs[i].expState);
            check($sformatf("vec%0d_served", i), int'(served), vecs[i].expServed);
        end

        // Local request: served two edges after the request, door held DOORC.
        startup();
        applyStimulus(0, 0, 1, 0);
        servedAt = -1; doorCnt = 0; found = 0;
        for (int n = 1; n <= 40 && !found; n++) begin
            applyStimulus(0, 0, 0, 0);
            if (served && servedAt < 0) begin servedAt = n; servedFl = int'(served_floor); end
            if (door_open) doorCnt++;
            if (doorCnt > 0 && !door_open) found = 1;
        end
        check("local_served_at", servedAt, 2);
        check("local_served_floor", servedFl, 0);
        check("local_door_cycles", doorCnt, DOORC);
        applyStimulus(0, 0, 0, 0);
        check("local_back_idle", int'(db_state), S_IDLE);

        // Travel two floors up: serve lands 2 + 2*(TRAVEL+2) edges later.
        startup();
        applyStimulus(0, 0, 1, 2);
        servedAt = -1; servedFl = -1; upCnt = 0;
        for (int n = 1; n <= 40 && servedAt < 0; n++) begin
            applyStimulus(0, 0, 0, 0);
            if (moving_up) upCnt++;
            if (served) begin servedAt = n; servedFl = int'(served_floor); end
        end
        check("travel_served_at", servedAt, 2 + 2 * (TRAVEL + 2));
        check("travel_served_floor", servedFl, 2);
        check("travel_up_cycles", upCnt, 2 * TRAVEL);

        // Reset during the second MOVE cycle, then restart.
        startup();
        applyStimulus(0, 0, 1, 5);
        found = 0;
        for (int n = 0; n < 10 && !found; n++) begin
            applyStimulus(0, 0, 0, 0);
            if (moving_up) found = 1;
        end
        check("rstmove_reached_move", int'(found), 1);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        check("rstmove_state", int'(db_state), S_OFF);
        check("rstmove_pending", int'(pending), 0);
        check("rstmove_floor", int'(current_floor), 0);
        check("rstmove_up", int'(moving_up), 0);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0);
        check("rstmove_restart_idle", int'(db_state), S_IDLE);

        // SCAN order: car at 3 heading to 6, then 1 and 5 arrive mid-travel.
        applyStimulus(0, 0, 1, 3);
        waitDoorThenIdle("scan_setup_floor3", 200);
        check("scan_at_floor3", int'(current_floor), 3);
        applyStimulus(0, 0, 1, 6);
        found = 0;
        for (int n = 0; n < 10 && !found; n++) begin
            applyStimulus(0, 0, 0, 0);
            if (moving_up) found = 1;
        end
        check("scan_moving", int'(found), 1);
        applyStimulus(0, 0, 1, 1);
        applyStimulus(0, 0, 1, 5);
        downEarly = 0; upLate = 0; seen6 = 0;
        for (int n = 0; n < 300 && order.size() < 3; n++) begin
            applyStimulus(0, 0, 0, 0);
            if (moving_down && !seen6) downEarly = 1;
            if (moving_up && seen6) upLate = 1;
            if (served) begin
                order.push_back(int'(served_floor));
                if (served_floor == FW'(6)) seen6 = 1;
            end
        end
        check("scan_count", order.size(), 3);
        if (order.size() == 3) begin
            check("scan_first", order[0], 5);
            check("scan_second", order[1], 6);
            check("scan_third", order[2], 1);
        end
        check("scan_down_before_6", int'(downEarly), 0);
        check("scan_up_after_6", int'(upLate), 0);
        waitDoorThenIdle("scan_finish", 200);

        // Request for floor 4 in the same DECIDE edge that serves floor 4.
        applyStimulus(0, 0, 1, 4);
        hit = 0; servedCnt = 0; found = 0;
        for (int n = 0; n < 200 && !found; n++) begin
            bit v;
            v = !hit && db_state == 3'(S_DECIDE) && current_floor == FW'(4);
            if (v) hit = 1;
            applyStimulus(0, 0, v, 4);
            if (served) servedCnt++;
            if (hit && db_state == 3'(S_IDLE)) found = 1;
        end
        check("simul_hit", int'(hit), 1);
        check("simul_idle", int'(found), 1);
        check("simul_served_once", servedCnt, 1);
        check("simul_bit4_clear", int'(pending[4]), 0);

        // Randomized traffic with occasional resets and restarts.
        for (int n = 0; n < 4000; n++) begin
            applyStimulus($urandom_range(0, 499) == 0,
                          $urandom_range(0, 7) == 0,
                          $urandom_range(0, 3) == 0,
                          int'($urandom_range(0, 15)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/elevator_scan_controller.md
# elevator_scan_controller

Parametrised successor to the single-request elevator control unit. It owns the datapath that the older unit left external: the pending-request bitmap, the current-floor register and the travel/door timer. It schedules with a SCAN policy: the car keeps its direction while requests remain ahead. It sits between the floor-button request logic and the car/door actuators and display.

## Interface
- `N_FLOORS`, default 8: number of floors, 2..2^`FLOOR_W`.
- `FLOOR_W`, default 3: width of floor indices.
- `TRAVEL_CYCLES`, default 100: clock cycles to travel one floor, ≥1.
- `DOOR_CYCLES`, default 200: clock cycles the door stays open, ≥1.
- `TIMER_W`, default 16: timer width; must hold max(`TRAVEL_CYCLES`, `DOOR_CYCLES`).

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `iniciar` in 1: leaves OFF.
- `req_valid` in 1: request strobe.
- `req_floor` in `FLOOR_W`: requested floor.
- `current_floor` out `FLOOR_W`: car position.
- `pending` out `N_FLOORS`: outstanding request bitmap.
- `moving_up` out 1: car is travelling up.
- `moving_down` out 1: car is travelling down.
- `door_open` out 1: door is open.
- `served` out 1: one-cycle pulse when a floor is served.
- `served_floor` out `FLOOR_W`: floor served, valid with `served`.
- `db_state` out 3: state code for debug.

## Operation
- States and codes: OFF=0, INIT=1, IDLE=2, DECIDE=3, MOVE=4, STEP=5, DOOR=6. Unused codes go to OFF.
- Internal `dir` register: 1 = up. Reset value is 1.
- OFF: go to INIT when `iniciar`=1, else stay.
- INIT: clear `pending`, set `current_floor`=0, set `dir`=1. Go to IDLE.
- IDLE: go to DECIDE when `pending`≠0, else stay.
- DECIDE, evaluated in priority order:
  - If `pending[current_floor]` is set: clear that bit and go to DOOR.
  - Else, if `dir`=1 and any bit above `current_floor` is set: go to MOVE, keep `dir`=1.
  - Else, if any bit below is set: set `dir`=0 and go to MOVE.
  - Else, if any bit above is set: set `dir`=1 and go to MOVE.
  - Else: go to IDLE.
- MOVE: timer counts from 0. When the timer equals `TRAVEL_CYCLES`-1, go to STEP.
- STEP: `current_floor` ±1 according to `dir`. Go to DECIDE.
- DOOR: timer counts from 0. When the timer equals `DOOR_CYCLES`-1, go to DECIDE.
- Timer behaviour: cleared on entry to MOVE and DOOR, held at 0 elsewhere.
- Request capture: when `req_valid`=1 and the state is IDLE, DECIDE, MOVE or STEP, set `pending[req_floor]`.
- Ignored requests:
  - `req_floor` ≥ `N_FLOORS`.
  - Any request in OFF or INIT.
  - In DOOR, a request equal to `current_floor` (the door is already open). Other floors are accepted.
- Simultaneous set and clear of the same bit in DECIDE: clear wins.
- Output decode:
  - `moving_up` = (MOVE && `dir`).
  - `moving_down` = (MOVE && !`dir`).
  - `door_open` = DOOR.
  - `served` is high only in the first DOOR cycle. `served_floor` = `current_floor` while `served`=1, else 0.
- The car never leaves 0..`N_FLOORS`-1. DECIDE selects MOVE only toward a set bit, so no wrap-around is possible.

## Timing
- Reset, from any state including mid-MOVE or mid-DOOR: next cycle the state is OFF.
  - All outputs read 0: `current_floor`, `pending`, `moving_*`, `door_open`, `served`, `served_floor`, `db_state`.
  - Timer = 0, `dir`=1.
- Request latency: the `pending` bit is visible the cycle after the `req_valid` edge.
- Request at the current floor while IDLE, `req_valid` at edge k:
  - IDLE→DECIDE at k+1.
  - DOOR with `served`=1 at k+2.
  - `door_open` lasts `DOOR_CYCLES` cycles.
- Per floor of travel: `TRAVEL_CYCLES` MOVE cycles + 1 STEP + 1 DECIDE.
- All outputs are registered or a pure decode of registered state. There is no combinational path from input to output.

## Test plan
- Reset mid-MOVE: with `TRAVEL_CYCLES`=4, assert `reset` in MOVE cycle 2 → next cycle state=0, `pending`=0, `current_floor`=0, `moving_up`=0. Asserting `iniciar` returns to IDLE two cycles later.
- Local request: idle at floor 0, request floor 0 → `served`=1 with `served_floor`=0 exactly 2 cycles after the request edge. `door_open` high for `DOOR_CYCLES`, then the state returns to IDLE.
- Travel: `TRAVEL_CYCLES`=4, request floor 2 from floor 0 → `moving_up` for 4 cycles twice, with `current_floor` 0→1→2. `served_floor`=2 on cycle 2+2·(4+2)=14 after the request edge.
- SCAN order:
  - Setup: car at 3 moving up toward 6; inject requests for 1 and 5 during MOVE.
  - Required: served order 5, 6, 1, with `dir` flipping only after 6 is served.
- Ignored requests:
  - `req_floor`=9 with `N_FLOORS`=8: `pending` unchanged.
  - Request of `current_floor` during DOOR: `pending` unchanged.
  - Any request in OFF: `pending` unchanged.
- Simultaneous: `req_valid` for floor 4 in the same DECIDE cycle that serves floor 4 → bit 4 clear afterward and exactly one `served` pulse.
